// File: rtl/multi_bar_graph_controller.sv
// Draws N_BARS horizontal bar graphs on an SSD1331 OLED as FILL/CLEAR rectangle
// commands, redrawing only bars whose clamped value changed since the last update.
module multi_bar_graph_controller #(
  parameter int N_BARS  = 2,
  parameter int BAR_H   = 16,
  parameter int BAR_GAP = 4,
  parameter int ROW0    = 0,
  parameter int COL_MAX = 95,
  parameter int TH0     = 16,
  parameter int TH1     = 32,
  parameter int TH2     = 48,
  parameter int TH3     = 72
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  en_i,
  input  logic                  force_i,
  input  logic [8*N_BARS-1:0]   y_i,
  input  logic                  spi_done_i,
  output logic                  spi_en,
  output logic [7:0]            data_o,
  output logic                  dc_o,
  output logic                  busy_o,
  output logic                  done_o
);

  // state    | meaning
  // IDLE     | waiting for en_i
  // PREAMBLE | set up the one-time fill-enable command (26 01)
  // SELECT   | decide whether bar r_bar needs a redraw
  // LOAD     | wait for spi_done_i low, present the byte
  // SEND     | spi_en high until spi_done_i
  // NEXT     | advance byte index / sub-phase / bar
  // DONE     | one-cycle completion, done_o pulses next cycle
  typedef enum logic [2:0] {
    S_IDLE, S_PREAMBLE, S_SELECT, S_LOAD, S_SEND, S_NEXT, S_DONE
  } state_t;

  typedef enum logic [1:0] {PH_PRE, PH_FILL, PH_CLEAR} phase_t;

  localparam logic [7:0] COL_MAX_B = 8'(COL_MAX);
  localparam logic [1:0] LAST_BAR  = 2'(N_BARS - 1);
  localparam logic [3:0] LAST_RECT = 4'd10;
  localparam logic [3:0] LAST_PRE  = 4'd1;

  if (N_BARS < 1 || N_BARS > 4 ||
      ROW0 + N_BARS*(BAR_H+BAR_GAP) - BAR_GAP > 64) begin : g_bad_params
    $error("multi_bar_graph_controller: bar layout does not fit the panel");
  end

  state_t              r_state;
  state_t              w_next;
  phase_t              r_phase;
  logic [3:0]          r_idx;
  logic [1:0]          r_bar;
  logic                r_force;
  logic                r_fill_on;
  logic [7:0]          r_snap  [N_BARS];
  logic [7:0]          r_cache [N_BARS];
  logic [N_BARS-1:0]   r_valid;

  logic [N_BARS-1:0]   w_bar_onehot;
  logic [7:0]          w_y;
  logic [7:0]          w_cache_y;
  logic                w_need;
  logic                w_need_clear;
  logic                w_last_byte;
  logic                w_last_bar;
  logic [15:0]         w_rgb;
  logic [7:0]          w_ch_a;
  logic [7:0]          w_ch_b;
  logic [7:0]          w_ch_c;
  logic [7:0]          w_col_s;
  logic [7:0]          w_col_e;
  logic [7:0]          w_row_s;
  logic [7:0]          w_row_e;
  logic [7:0]          w_byte;
  logic                w_spi_en_d;
  logic                w_busy_d;
  logic                w_done_d;

  function automatic logic [15:0] colour_of(input logic [7:0] y);
    int yi;
    yi = int'(y);
    if (yi < TH0)      return 16'hF800;
    else if (yi < TH1) return 16'hFC00;
    else if (yi < TH2) return 16'hFFE0;
    else if (yi < TH3) return 16'h87E0;
    else               return 16'h07E0;
  endfunction

  always_comb begin
    w_bar_onehot = '0;
    w_y          = '0;
    w_cache_y    = '0;
    for (int k = 0; k < N_BARS; k++) begin
      w_bar_onehot[k] = (r_bar == 2'(k));
      if (r_bar == 2'(k)) begin
        w_y       = r_snap[k];
        w_cache_y = r_cache[k];
      end
    end
  end

  assign w_need       = r_force || ((r_valid & w_bar_onehot) == '0) || (w_y != w_cache_y);
  assign w_need_clear = (w_y < COL_MAX_B);
  assign w_last_byte  = (r_phase == PH_PRE) ? (r_idx == LAST_PRE) : (r_idx == LAST_RECT);
  assign w_last_bar   = (r_bar == LAST_BAR);

  // state register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (en_i) w_next = r_fill_on ? S_SELECT : S_PREAMBLE;
      S_PREAMBLE: w_next = S_LOAD;
      S_SELECT: begin
        if (w_need)          w_next = S_LOAD;
        else if (w_last_bar) w_next = S_DONE;
      end
      S_LOAD:     if (!spi_done_i) w_next = S_SEND;
      S_SEND:     if (spi_done_i)  w_next = S_NEXT;
      S_NEXT: begin
        if (!w_last_byte) begin
          w_next = S_LOAD;
        end else begin
          case (r_phase)
            PH_PRE:  w_next = S_SELECT;
            PH_FILL: w_next = w_need_clear ? S_LOAD : (w_last_bar ? S_DONE : S_SELECT);
            default: w_next = w_last_bar ? S_DONE : S_SELECT;
          endcase
        end
      end
      S_DONE:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // output logic: command byte mux and next values of the registered outputs
  always_comb begin
    w_rgb   = colour_of(w_y);
    w_ch_a  = {2'b00, w_rgb[15:11], 1'b0};
    w_ch_b  = {2'b00, w_rgb[10:5]};
    w_ch_c  = {2'b00, w_rgb[4:0], 1'b0};
    w_row_s = 8'(ROW0 + int'(r_bar) * (BAR_H + BAR_GAP));
    w_row_e = w_row_s + 8'(BAR_H - 1);
    w_col_s = 8'h00;
    w_col_e = w_y;
    if (r_phase == PH_CLEAR) begin
      w_ch_a  = 8'h00;
      w_ch_b  = 8'h00;
      w_ch_c  = 8'h00;
      w_col_s = w_y + 8'd1;
      w_col_e = COL_MAX_B;
    end

    w_byte = 8'h00;
    if (r_phase == PH_PRE) begin
      w_byte = (r_idx == 4'd0) ? 8'h26 : 8'h01;
    end else begin
      case (r_idx)
        4'd0:        w_byte = 8'h22;
        4'd1:        w_byte = w_col_s;
        4'd2:        w_byte = w_row_s;
        4'd3:        w_byte = w_col_e;
        4'd4:        w_byte = w_row_e;
        4'd5, 4'd8:  w_byte = w_ch_c;
        4'd6, 4'd9:  w_byte = w_ch_b;
        4'd7, 4'd10: w_byte = w_ch_a;
        default:     w_byte = 8'h00;
      endcase
    end

    w_spi_en_d = (w_next == S_SEND);
    w_busy_d   = (w_next != S_IDLE);
    w_done_d   = (r_state == S_DONE);
  end

  assign dc_o = 1'b0;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      spi_en    <= 1'b0;
      data_o    <= 8'h00;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      r_phase   <= PH_PRE;
      r_idx     <= '0;
      r_bar     <= '0;
      r_force   <= 1'b0;
      r_fill_on <= 1'b0;
      r_valid   <= '0;
      for (int k = 0; k < N_BARS; k++) begin
        r_snap[k]  <= '0;
        r_cache[k] <= '0;
      end
    end else begin
      spi_en <= w_spi_en_d;
      busy_o <= w_busy_d;
      done_o <= w_done_d;
      case (r_state)
        S_IDLE: begin
          if (en_i) begin
            r_force <= force_i;
            r_bar   <= '0;
            for (int k = 0; k < N_BARS; k++)
              r_snap[k] <= (y_i[8*k +: 8] > COL_MAX_B) ? COL_MAX_B : y_i[8*k +: 8];
          end
        end
        S_PREAMBLE: begin
          r_phase <= PH_PRE;
          r_idx   <= '0;
        end
        S_SELECT: begin
          if (w_need) begin
            r_phase <= PH_FILL;
            r_idx   <= '0;
          end else if (!w_last_bar) begin
            r_bar <= r_bar + 2'd1;
          end
        end
        S_LOAD: if (!spi_done_i) data_o <= w_byte;
        S_NEXT: begin
          if (!w_last_byte) begin
            r_idx <= r_idx + 4'd1;
          end else if (r_phase == PH_PRE) begin
            r_fill_on <= 1'b1;
          end else if (r_phase == PH_FILL && w_need_clear) begin
            r_phase <= PH_CLEAR;
            r_idx   <= '0;
          end else begin
            // bar finished: remember what is now on the panel
            r_valid <= r_valid | w_bar_onehot;
            for (int k = 0; k < N_BARS; k++)
              if (w_bar_onehot[k]) r_cache[k] <= w_y;
            if (!w_last_bar) r_bar <= r_bar + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_bar_graph_controller.sv
// Directed bench for multi_bar_graph_controller: logs every SPI byte through a
// simple handshake responder and compares against hand-computed command streams.
module tb_multi_bar_graph_controller;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        en_i;
  logic        force_i;
  logic [15:0] y_i;
  logic        spi_done_i;
  logic        spi_en;
  logic [7:0]  data_o;
  logic        dc_o;
  logic        busy_o;
  logic        done_o;

  multi_bar_graph_controller dut (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .en_i       (en_i),
    .force_i    (force_i),
    .y_i        (y_i),
    .spi_done_i (spi_done_i),
    .spi_en     (spi_en),
    .data_o     (data_o),
    .dc_o       (dc_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  always #5 clk_i = ~clk_i;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  byte_log [$];
  int          dc_bad   = 0;
  int          done_cnt = 0;
  logic        hold_done = 1'b0;
  logic        busy_at1;
  int          lat;

  logic [7:0] exp_first [35] = '{
    8'h26, 8'h01,
    8'h22, 8'h00, 8'h00, 8'h28, 8'h0F, 8'h00, 8'h3F, 8'h3E, 8'h00, 8'h3F, 8'h3E,
    8'h22, 8'h29, 8'h00, 8'h5F, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
    8'h22, 8'h00, 8'h14, 8'h5F, 8'h23, 8'h00, 8'h3F, 8'h00, 8'h00, 8'h3F, 8'h00};

  logic [7:0] exp_red [22] = '{
    8'h22, 8'h00, 8'h00, 8'h0A, 8'h0F, 8'h00, 8'h00, 8'h3E, 8'h00, 8'h00, 8'h3E,
    8'h22, 8'h0B, 8'h00, 8'h5F, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // SPI engine stand-in: answers each byte 3 cycles after spi_en, or holds done high
  initial begin
    spi_done_i = 1'b0;
    forever begin
      @(negedge clk_i);
      if (hold_done) begin
        spi_done_i = 1'b1;
      end else if (spi_en) begin
        byte_log.push_back(data_o);
        if (dc_o !== 1'b0) dc_bad++;
        repeat (3) @(negedge clk_i);
        spi_done_i = 1'b1;
        @(negedge clk_i);
        spi_done_i = 1'b0;
      end else begin
        spi_done_i = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk_i);
      if (done_o) done_cnt++;
    end
  end

  task automatic run_update(input logic frc, output int latency);
    byte_log.delete();
    done_cnt = 0;
    latency  = -1;
    @(negedge clk_i);
    en_i    = 1'b1;
    force_i = frc;
    for (int c = 1; c <= 3000; c++) begin
      @(negedge clk_i);
      en_i    = 1'b0;
      force_i = 1'b0;
      if (c == 1) busy_at1 = busy_o;
      if (done_o) begin
        latency = c;
        break;
      end
    end
    check_eq("update_completes", 32'(latency > 0), 1);
    repeat (3) @(negedge clk_i);
  endtask

  task automatic wait_log(input int n);
    for (int c = 0; c < 2000 && byte_log.size() < n; c++) @(negedge clk_i);
    check_eq("log_reached", 32'(byte_log.size() >= n), 1);
  endtask

  initial begin
    rstn_i  = 1'b0;
    en_i    = 1'b0;
    force_i = 1'b0;
    y_i     = {8'd100, 8'd40};
    repeat (3) @(negedge clk_i);
    check_eq("rst_spi_en", spi_en, 0);
    check_eq("rst_data",   data_o, 0);
    check_eq("rst_dc",     dc_o,   0);
    check_eq("rst_busy",   busy_o, 0);
    check_eq("rst_done",   done_o, 0);
    rstn_i = 1'b1;
    repeat (2) @(negedge clk_i);

    // first update: preamble, bar0 fill+clear, bar1 clamped fill
    run_update(1'b0, lat);
    check_eq("t1_busy_rise", busy_at1, 1);
    check_eq("t1_nbytes", byte_log.size(), 35);
    for (int i = 0; i < 35 && i < byte_log.size(); i++)
      check_eq($sformatf("t1_byte%0d", i), byte_log[i], exp_first[i]);
    check_eq("t1_done_cnt", done_cnt, 1);
    check_eq("t1_busy_end", busy_o, 0);

    // same values: nothing drawn, done after 2+N_BARS cycles
    run_update(1'b0, lat);
    check_eq("t2_latency", lat, 4);
    check_eq("t2_nbytes", byte_log.size(), 0);
    check_eq("t2_done_cnt", done_cnt, 1);

    // only bar0 changes, to red
    y_i = {8'd100, 8'd10};
    run_update(1'b0, lat);
    check_eq("t3_nbytes", byte_log.size(), 22);
    for (int i = 0; i < 22 && i < byte_log.size(); i++)
      check_eq($sformatf("t3_byte%0d", i), byte_log[i], exp_red[i]);

    // force redraw, unchanged values
    run_update(1'b1, lat);
    check_eq("t4_nbytes", byte_log.size(), 33);
    if (byte_log.size() >= 33) begin
      check_eq("t4_first",    byte_log[0],  8'h22);
      check_eq("t4_b0_red",   byte_log[7],  8'h3E);
      check_eq("t4_b1_start", byte_log[22], 8'h22);
      check_eq("t4_b1_row",   byte_log[24], 8'h14);
      check_eq("t4_b1_rowe",  byte_log[26], 8'h23);
    end

    // stuck spi_done_i plus ignored en_i while busy
    byte_log.delete();
    done_cnt  = 0;
    hold_done = 1'b1;
    y_i       = {8'd50, 8'd10};
    repeat (2) @(negedge clk_i);
    en_i = 1'b1;
    @(negedge clk_i);
    en_i = 1'b0;
    @(negedge clk_i);
    en_i = 1'b1;
    @(negedge clk_i);
    en_i = 1'b0;
    repeat (10) @(negedge clk_i);
    check_eq("t5_stall_spi_en", spi_en, 0);
    check_eq("t5_stall_busy",   busy_o, 1);
    hold_done = 1'b0;
    wait_log(22);
    for (int c = 0; c < 200 && done_cnt == 0; c++) @(negedge clk_i);
    repeat (10) @(negedge clk_i);
    check_eq("t5_nbytes", byte_log.size(), 22);
    if (byte_log.size() >= 22) begin
      check_eq("t5_cmd",    byte_log[0],  8'h22);
      check_eq("t5_row",    byte_log[2],  8'h14);
      check_eq("t5_col_e",  byte_log[3],  8'h32);
      check_eq("t5_c",      byte_log[5],  8'h00);
      check_eq("t5_b",      byte_log[6],  8'h3F);
      check_eq("t5_a",      byte_log[7],  8'h20);
      check_eq("t5_clr_cs", byte_log[12], 8'h33);
    end
    check_eq("t5_done_cnt", done_cnt, 1);
    check_eq("t5_idle",     busy_o,   0);

    // reset in the middle of bar1 FILL
    byte_log.delete();
    @(negedge clk_i);
    en_i    = 1'b1;
    force_i = 1'b1;
    @(negedge clk_i);
    en_i    = 1'b0;
    force_i = 1'b0;
    wait_log(24);
    @(negedge clk_i);
    #2 rstn_i = 1'b0;
    #1;
    check_eq("t6_rst_spi_en", spi_en, 0);
    check_eq("t6_rst_busy",   busy_o, 0);
    check_eq("t6_rst_data",   data_o, 0);
    check_eq("t6_rst_done",   done_o, 0);
    repeat (3) @(negedge clk_i);
    rstn_i = 1'b1;
    repeat (10) @(negedge clk_i);
    run_update(1'b0, lat);
    check_eq("t6_nbytes", byte_log.size(), 46);
    if (byte_log.size() >= 46) begin
      check_eq("t6_pre0",    byte_log[0],  8'h26);
      check_eq("t6_pre1",    byte_log[1],  8'h01);
      check_eq("t6_b0",      byte_log[2],  8'h22);
      check_eq("t6_b1",      byte_log[24], 8'h22);
      check_eq("t6_b1_row",  byte_log[26], 8'h14);
    end

    check_eq("dc_always_0", dc_bad, 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
